// File: rtl/serdes_pkg.sv
// serdes_pkg: shared state encoding and constants for the SERDES receive buffer; PARITY_CHECK_EN selects 9-bit parity frames
package serdes_pkg;
   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;
   localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
   localparam logic [7:0] ERR_CHAR_DEF  = 8'h3F;
   localparam int LOS_COUNT_DEF = 4;
   localparam int DATA_BITS = 8;
   localparam int RAM_DEPTH = 32;
   localparam int ADDR_W = 5;
`ifdef PARITY_CHECK_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif
   localparam int FRAME_LEN = PARITY_EN ? DATA_BITS + 1 : DATA_BITS;
endpackage

// File: rtl/char_ram_32x8.sv
// char_ram_32x8: 32x8 character RAM, synchronous write, combinational read
module char_ram_32x8 import serdes_pkg::*; (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);
   logic [7:0] mem_q [RAM_DEPTH];
   // write port; contents are deliberately not reset
   always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/serdes_rx_charbuf.sv
// serdes_rx_charbuf: sync hunt, frame assembly and character RAM writer; PARITY_CHECK_EN enables parity, error counting and loss of sync
module serdes_rx_charbuf import serdes_pkg::*; #(
   parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF,
   parameter int         LOS_COUNT = LOS_COUNT_DEF,
   parameter logic [7:0] ERR_CHAR  = ERR_CHAR_DEF
) (
   input  logic       Clk50,
   input  logic       resetN,
   input  logic       serIn,
   input  logic       bitValid,
   input  logic       oneSecTick,
   input  logic [4:0] rdAddr,
   output logic [7:0] dataFromMem,
   output logic [4:0] MCC,
   output logic       syncState,
   output logic [7:0] errPerSec
);
   state_e     state_q, state_d;
   logic [7:0] hunt_q, hunt_d, shift_q, win_q, eps_q, consec_q, wr_data_q;
   logic [3:0] bitcnt_q;
   logic [4:0] mcc_q;
   logic       par_q, wr_pend_q, wr_bad_q;
   logic       hunt_hit, take, last_bit, frame_bad, err, los;

   assign hunt_d    = {hunt_q[6:0], serIn};
   assign hunt_hit  = bitValid && state_q == HUNT && hunt_d == SYNC_WORD;
   assign err       = wr_pend_q && wr_bad_q;
   assign los       = err && consec_q + 8'd1 == 8'(LOS_COUNT);
   assign take      = bitValid && state_q == LOCKED && !los;
   assign last_bit  = take && bitcnt_q == 4'(FRAME_LEN - 1);
   assign frame_bad = PARITY_EN && (par_q ^ serIn);

   // lock state register
   always_ff @(posedge Clk50 or negedge resetN)
      if (!resetN) state_q <= HUNT;
      else state_q <= state_d;

   // lock on sync word, drop lock when the error run reaches LOS_COUNT
   always_comb state_d = hunt_hit ? LOCKED : los ? HUNT : state_q;

   // hunting flag follows the state directly
   always_comb syncState = state_q == HUNT;

   // sync hunt shifter and frame assembly; completed frames go to a separate capture stage
   always_ff @(posedge Clk50 or negedge resetN)
      if (!resetN) begin
         hunt_q    <= '0;
         shift_q   <= '0;
         bitcnt_q  <= '0;
         par_q     <= 1'b0;
         wr_pend_q <= 1'b0;
         wr_bad_q  <= 1'b0;
         wr_data_q <= '0;
      end else begin
         wr_pend_q <= last_bit;
         if (last_bit) begin
            wr_data_q <= frame_bad ? ERR_CHAR : PARITY_EN ? shift_q : {shift_q[6:0], serIn};
            wr_bad_q  <= frame_bad;
         end
         if (los) hunt_q <= '0;
         else if (bitValid && state_q == HUNT) hunt_q <= hunt_d;
         if (hunt_hit || los) begin
            bitcnt_q <= '0;
            par_q    <= 1'b0;
         end else if (take) begin
            bitcnt_q <= last_bit ? 4'd0 : bitcnt_q + 4'd1;
            par_q    <= last_bit ? 1'b0 : par_q ^ serIn;
            if (bitcnt_q < 4'(DATA_BITS)) shift_q <= {shift_q[6:0], serIn};
         end
      end

   // commit stage: advance write pointer and track the consecutive error run
   always_ff @(posedge Clk50 or negedge resetN)
      if (!resetN) begin
         mcc_q    <= '0;
         consec_q <= '0;
      end else begin
         if (wr_pend_q) mcc_q <= mcc_q + 5'd1;
         if (los || (wr_pend_q && !wr_bad_q)) consec_q <= '0;
         else if (err) consec_q <= consec_q + 8'd1;
      end

   // per-second error window; an error on the tick edge opens the new window at 1
   always_ff @(posedge Clk50 or negedge resetN)
      if (!resetN) begin
         win_q <= '0;
         eps_q <= '0;
      end else if (oneSecTick) begin
         eps_q <= win_q;
         win_q <= {7'd0, err};
      end else if (err && win_q != 8'hFF) win_q <= win_q + 8'd1;

   char_ram_32x8 u_ram (
      .clk_i   (Clk50),
      .we_i    (wr_pend_q),
      .waddr_i (mcc_q),
      .wdata_i (wr_data_q),
      .raddr_i (rdAddr),
      .rdata_o (dataFromMem)
   );

   assign MCC       = mcc_q;
   assign errPerSec = eps_q;
endmodule

// File: tb/tb_serdes_rx_charbuf.sv
// tb_serdes_rx_charbuf: randomized scoreboard bench for serdes_rx_charbuf; honours PARITY_CHECK_EN
module tb_serdes_rx_charbuf;
   import serdes_pkg::*;
   logic       Clk50 = 1'b0, resetN = 1'b0, serIn = 1'b0, bitValid = 1'b0, oneSecTick = 1'b0;
   logic [4:0] rdAddr, MCC, prev, probe_addr;
   logic [7:0] dataFromMem, errPerSec;
   logic       syncState;
   bit         probe = 1'b0;
   int         n_chk = 0, n_fail = 0;
   logic [7:0] exp_q [$];
   logic [7:0] ram_m [32];
   bit         m_locked;
   int         m_consec, m_win, m_eps, m_mcc;

   always #10 Clk50 = ~Clk50;

   serdes_rx_charbuf dut (
      .Clk50       (Clk50),
      .resetN      (resetN),
      .serIn       (serIn),
      .bitValid    (bitValid),
      .oneSecTick  (oneSecTick),
      .rdAddr      (rdAddr),
      .dataFromMem (dataFromMem),
      .MCC         (MCC),
      .syncState   (syncState),
      .errPerSec   (errPerSec)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every advance of MCC must reveal the next expected character at the old address
   initial begin
      logic [7:0] e;
      logic [4:0] nx;
      prev = '0;
      rdAddr = '0;
      forever begin
         @(negedge Clk50);
         if (!resetN) prev = '0;
         else if (MCC !== prev) begin
            if (exp_q.size() == 0) chk("unexpected_write", MCC, prev);
            else begin
               e = exp_q.pop_front();
               nx = prev + 5'd1;
               chk("wr_data", dataFromMem, e);
               chk("wr_addr", MCC, nx);
            end
            prev = MCC;
         end
         rdAddr = probe ? probe_addr : prev;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clk50);
         #1;
      end
   endtask

   task automatic bit_out(input logic b);
      serIn = b;
      bitValid = 1'b1;
      @(posedge Clk50);
      #1 bitValid = 1'b0;
      serIn = 1'($urandom);
   endtask

   task automatic model_reset();
      m_locked = 0;
      m_consec = 0;
      m_win = 0;
      m_eps = 0;
      m_mcc = 0;
      exp_q.delete();
   endtask

   task automatic send_sync();
      logic [7:0] s;
      s = SYNC_WORD_DEF;
      for (int i = 7; i >= 0; i--) bit_out(s[i]);
      m_locked = 1;
      m_consec = 0;
      chk("sync_lock", syncState, 0);
   endtask

   task automatic tick();
      oneSecTick = 1'b1;
      @(posedge Clk50);
      #1 oneSecTick = 1'b0;
      m_eps = m_win;
      m_win = 0;
      chk("errPerSec", errPerSec, m_eps);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad, input bit tick_end, input bit gaps, input bit b2b);
      logic [8:0] f;
      logic [7:0] c;
      int nb;
      bit e;
      f = {d, ^d ^ bad};
      nb = PARITY_EN ? 9 : 8;
      for (int i = 0; i < nb; i++) begin
         if (gaps) idle($urandom_range(0, 2));
         bit_out(f[8-i]);
      end
      e = PARITY_EN && bad && m_locked;
      if (m_locked) begin
         c = e ? ERR_CHAR_DEF : d;
         exp_q.push_back(c);
         ram_m[m_mcc] = c;
         m_mcc = (m_mcc + 1) % 32;
         m_consec = e ? m_consec + 1 : 0;
      end
      if (!b2b) begin
         oneSecTick = tick_end;
         @(posedge Clk50);
         #1 oneSecTick = 1'b0;
      end
      if (tick_end) begin
         m_eps = m_win;
         m_win = e ? 1 : 0;
      end else if (e && m_win < 255) m_win++;
      if (m_consec == LOS_COUNT_DEF) begin
         m_locked = 0;
         m_consec = 0;
      end
      if (!b2b) begin
         chk("syncState", syncState, !m_locked);
         chk("MCC", MCC, m_mcc);
      end
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      idle(2);
      resetN = 1'b1;
      model_reset();
      idle(1);
      chk("rst_MCC", MCC, 0);
      chk("rst_syncState", syncState, 1);
      chk("rst_errPerSec", errPerSec, 0);
   endtask

   initial begin
      model_reset();
      do_reset();
      send_sync();
      send_frame(8'h48, 0, 0, 0, 0);
      send_frame(8'h49, 0, 0, 1, 0);
      chk("two_chars", MCC, 2);
      send_frame(8'h41, 1, 0, 0, 0);
      tick();
      send_frame(8'h55, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1, 0, 1, 0);
      send_frame(8'h48, 0, 0, 0, 0);
      if (!m_locked) send_sync();
      tick();
      send_frame(8'($urandom), 1, 0, 0, 0);
      send_frame(8'($urandom), 0, 0, 0, 0);
      send_frame(8'($urandom), 1, 0, 0, 0);
      send_frame(8'($urandom), 0, 0, 0, 0);
      send_frame(8'($urandom), 1, 1, 0, 0);
      chk("same_edge_eps", errPerSec, m_eps);
      tick();
      for (int i = 0; i < 260; i++) begin
         if (!m_locked) send_sync();
         send_frame(8'($urandom), 1, 0, 0, 0);
      end
      tick();
      if (!m_locked) send_sync();
      for (int i = 0; i < 5; i++) bit_out(1'($urandom));
      do_reset();
      send_sync();
      for (int i = 0; i < 33; i++) send_frame(8'($urandom), 0, 0, 0, i < 32 ? 1'($urandom) : 1'b0);
      chk("wrap_MCC", MCC, 1);
      probe_addr = 5'd0;
      probe = 1'b1;
      idle(2);
      chk("ram0_after_wrap", dataFromMem, ram_m[0]);
      probe = 1'b0;
      idle(2);
      for (int i = 0; i < 150; i++) begin
         if (!m_locked) send_sync();
         send_frame(8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, 1'($urandom), 1'b0);
         if ($urandom_range(0, 9) == 0) tick();
      end
      idle(3);
      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
